npu_core_sequencer: RTL and testbench

Sequences one convolution layer through the 18-output NPU core. It joins the feature and weight streams into beats and drives the core's valid and accumulator-restart controls. It gates bias onto the first beat of each output pixel, latches the requantisation shift, and emits a delay-aligned output strobe with pixel index. It sits between the layer controller and feature/weight buffers on one side and the NPU core on the other.

---
 rtl/npu_pkg.sv | 26 ++
 rtl/npu_delay_line.sv | 49 ++++
 rtl/npu_core_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_npu_core_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// ---------------------------------------------------------------------------
// npu_pkg
// Shared definitions for the NPU core sequencer slice: sequencer state
// encoding and the default geometry/latency constants of the 18-output core.
// No ports (package).
// ---------------------------------------------------------------------------
package npu_pkg;

    // Output channels per core; one accumulator restart bit per channel.
    localparam int NPU_OUT_NUM   = 18;
    // Beats-per-pixel and pixel counter widths.
    localparam int ACC_CNT_WIDTH = 10;
    localparam int PIX_CNT_WIDTH = 16;
    // Cycles from beat issue to that beat's partial sum at the accumulator.
    localparam int ACC_ALIGN     = 11;
    // Cycles from last-beat issue to clipped data valid on the core output.
    localparam int OUT_LATENCY   = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/npu_delay_line.sv
// ---------------------------------------------------------------------------
// npu_delay_line
// Fixed-depth shift register with synchronous reset. Bit 0 of each word is a
// flag; any_set reports whether any stage currently holds a set flag.
// A word presented on din appears on dout exactly DEPTH cycles later.
//
// Ports:
//   clk      in   1      clock
//   rst      in   1      synchronous active-high reset (flushes all stages)
//   din      in   WIDTH  word entering the line (bit 0 = flag)
//   dout     out  WIDTH  word leaving the line (last stage)
//   any_set  out  1      OR of the flag bit across all stages
// ---------------------------------------------------------------------------
module npu_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             any_set
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_reg;
    logic [DEPTH-1:0]            flag_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flag
            assign flag_vec[gi] = stage_reg[gi][0];
        end
    endgenerate

    assign dout    = stage_reg[DEPTH-1];
    assign any_set = |flag_vec;

endmodule

// File: rtl/npu_core_sequencer.sv
// ---------------------------------------------------------------------------
// npu_core_sequencer
// Sequences one convolution layer through the NPU core. Feature and weight
// streams are joined into beats (both valid in the same cycle). Beats are
// counted per output pixel; the first beat of a pixel gates bias in and, after
// ACC_ALIGN cycles, restarts the accumulators. The last beat of a pixel, with
// its index, is delayed OUT_LATENCY cycles to flag finished output data.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_start                start pulse (accepted in IDLE only)
//   cfg_acc_len              beats per output pixel (0 treated as 1)
//   cfg_pix_num              output pixels in the layer
//   cfg_scale                requantisation right-shift, latched on start
//   feat_valid/feat_ready    feature stream handshake
//   wgt_valid/wgt_ready      weight stream handshake
//   npu_data_valid           core data-valid (= beat)
//   npu_weight_valid         core weight-valid (= beat)
//   npu_bias_en              bias passes on the first beat of a pixel
//   npu_adder_rst            accumulator restart, all bits identical
//   npu_scale                latched cfg_scale
//   out_valid, out_pix_idx   finished pixel strobe and its index
//   busy                     sequencer not idle
//   done                     one-cycle layer-complete pulse
// ---------------------------------------------------------------------------
module npu_core_sequencer #(
    parameter int NPU_OUT_NUM   = npu_pkg::NPU_OUT_NUM,
    parameter int ACC_CNT_WIDTH = npu_pkg::ACC_CNT_WIDTH,
    parameter int PIX_CNT_WIDTH = npu_pkg::PIX_CNT_WIDTH,
    parameter int ACC_ALIGN     = npu_pkg::ACC_ALIGN,
    parameter int OUT_LATENCY   = npu_pkg::OUT_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic [ACC_CNT_WIDTH-1:0] cfg_acc_len,
    input  logic [PIX_CNT_WIDTH-1:0] cfg_pix_num,
    input  logic [3:0]               cfg_scale,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic                     wgt_valid,
    output logic                     wgt_ready,
    output logic                     npu_data_valid,
    output logic                     npu_weight_valid,
    output logic                     npu_bias_en,
    output logic [NPU_OUT_NUM-1:0]   npu_adder_rst,
    output logic [3:0]               npu_scale,
    output logic                     out_valid,
    output logic [PIX_CNT_WIDTH-1:0] out_pix_idx,
    output logic                     busy,
    output logic                     done
);

    import npu_pkg::*;

    localparam logic [ACC_CNT_WIDTH-1:0] ACC_ONE = ACC_CNT_WIDTH'(1);
    localparam logic [PIX_CNT_WIDTH-1:0] PIX_ONE = PIX_CNT_WIDTH'(1);

    seq_state_t                 state_reg;
    logic [ACC_CNT_WIDTH-1:0]   acc_len_reg;
    logic [ACC_CNT_WIDTH-1:0]   acc_cnt_reg;
    logic [PIX_CNT_WIDTH-1:0]   pix_num_reg;
    logic [PIX_CNT_WIDTH-1:0]   pix_cnt_reg;
    logic [3:0]                 scale_reg;
    logic                       busy_reg;
    logic                       done_reg;

    logic                       beat;
    logic                       first_beat;
    logic                       last_beat;
    logic                       last_pix;

    logic                       first_tail;
    logic                       first_any;
    logic [PIX_CNT_WIDTH:0]     out_din;
    logic [PIX_CNT_WIDTH:0]     out_dout;
    logic                       out_any;

    // Joint handshake: both streams are accepted together or not at all.
    assign beat       = (state_reg == ST_RUN) & feat_valid & wgt_valid;
    assign first_beat = beat & (acc_cnt_reg == '0);
    assign last_beat  = beat & (acc_cnt_reg == acc_len_reg - ACC_ONE);
    assign last_pix   = (pix_cnt_reg == pix_num_reg - PIX_ONE);

    assign feat_ready       = beat;
    assign wgt_ready        = beat;
    assign npu_data_valid   = beat;
    assign npu_weight_valid = beat;
    assign npu_bias_en      = first_beat;

    // First-beat flag, aligned to the partial sum reaching the accumulator.
    npu_delay_line #(
        .WIDTH (1),
        .DEPTH (ACC_ALIGN)
    ) u_first_line (
        .clk     (clk),
        .rst     (rst),
        .din     (first_beat),
        .dout    (first_tail),
        .any_set (first_any)
    );

    // Last-beat flag in bit 0, pixel index above it. Idle slots carry zero so
    // the index output stays quiet between strobes.
    assign out_din = last_beat ? {pix_cnt_reg, 1'b1} : '0;

    npu_delay_line #(
        .WIDTH (PIX_CNT_WIDTH + 1),
        .DEPTH (OUT_LATENCY)
    ) u_out_line (
        .clk     (clk),
        .rst     (rst),
        .din     (out_din),
        .dout    (out_dout),
        .any_set (out_any)
    );

    assign npu_adder_rst = {NPU_OUT_NUM{first_tail}};
    assign out_valid     = out_dout[0];
    assign out_pix_idx   = out_dout[PIX_CNT_WIDTH:1];
    assign npu_scale     = scale_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            acc_len_reg <= '0;
            acc_cnt_reg <= '0;
            pix_num_reg <= '0;
            pix_cnt_reg <= '0;
            scale_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (cfg_start) begin
                        acc_len_reg <= (cfg_acc_len == '0) ? ACC_ONE : cfg_acc_len;
                        pix_num_reg <= cfg_pix_num;
                        scale_reg   <= cfg_scale;
                        acc_cnt_reg <= '0;
                        pix_cnt_reg <= '0;
                        busy_reg    <= 1'b1;
                        if (cfg_pix_num == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    // Bubbles hold the counters; only beats advance them.
                    if (beat) begin
                        if (last_beat) begin
                            acc_cnt_reg <= '0;
                            pix_cnt_reg <= pix_cnt_reg + PIX_ONE;
                            if (last_pix) begin
                                state_reg <= ST_DRAIN;
                            end
                        end else begin
                            acc_cnt_reg <= acc_cnt_reg + ACC_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The restart line always empties before the output line
                    // (shorter delay, earlier entry); waiting on both keeps
                    // DONE from being reported while any core control is
                    // still in flight.
                    if (!out_any && !first_any) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_npu_core_sequencer.sv
// ---------------------------------------------------------------------------
// tb_npu_core_sequencer
// Directed bench for npu_core_sequencer. A negedge monitor logs the relative
// cycle (from the cfg_start drive cycle) of every beat, bias enable, adder
// restart, output strobe and done pulse; each step compares the logged events
// against hand-computed cycle numbers.
// ---------------------------------------------------------------------------
module tb_npu_core_sequencer;

    localparam int NOUT = 18;
    localparam int AW   = 10;
    localparam int PW   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_start = 1'b0;
    logic [AW-1:0]   cfg_acc_len = '0;
    logic [PW-1:0]   cfg_pix_num = '0;
    logic [3:0]      cfg_scale = '0;
    logic            feat_valid = 1'b0;
    logic            feat_ready;
    logic            wgt_valid = 1'b0;
    logic            wgt_ready;
    logic            npu_data_valid;
    logic            npu_weight_valid;
    logic            npu_bias_en;
    logic [NOUT-1:0] npu_adder_rst;
    logic [3:0]      npu_scale;
    logic            out_valid;
    logic [PW-1:0]   out_pix_idx;
    logic            busy;
    logic            done;

    npu_core_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_start        (cfg_start),
        .cfg_acc_len      (cfg_acc_len),
        .cfg_pix_num      (cfg_pix_num),
        .cfg_scale        (cfg_scale),
        .feat_valid       (feat_valid),
        .feat_ready       (feat_ready),
        .wgt_valid        (wgt_valid),
        .wgt_ready        (wgt_ready),
        .npu_data_valid   (npu_data_valid),
        .npu_weight_valid (npu_weight_valid),
        .npu_bias_en      (npu_bias_en),
        .npu_adder_rst    (npu_adder_rst),
        .npu_scale        (npu_scale),
        .out_valid        (out_valid),
        .out_pix_idx      (out_pix_idx),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int t0 = 0;
    int vectors = 0;
    int miscompares = 0;
    int bad_cnt = 0;

    int beat_q[$];
    int bias_q[$];
    int arst_q[$];
    int ov_q[$];
    int idx_q[$];
    int done_q[$];

    int b_beat, b_bias, b_arst, b_ov, b_idx, b_done, b_bad;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log plus protocol sanity: ready never one-sided, ready only with
    // both valids, core valids equal to the handshake, restart bits uniform.
    always @(negedge clk) begin
        if (feat_ready)     beat_q.push_back(cyc - t0);
        if (npu_bias_en)    bias_q.push_back(cyc - t0);
        if (npu_adder_rst[0]) arst_q.push_back(cyc - t0);
        if (out_valid) begin
            ov_q.push_back(cyc - t0);
            idx_q.push_back(int'(out_pix_idx));
        end
        if (done)           done_q.push_back(cyc - t0);
        if (feat_ready != wgt_ready) bad_cnt++;
        if (feat_ready && !(feat_valid && wgt_valid)) bad_cnt++;
        if (npu_data_valid != feat_ready || npu_weight_valid != feat_ready) bad_cnt++;
        if (npu_adder_rst != '0 && npu_adder_rst != '1) bad_cnt++;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk_q(input string tag, input int q[$], input int base, input int exp[$]);
        chk({tag, "_n"}, q.size() - base, exp.size());
        foreach (exp[i]) chk($sformatf("%s%0d", tag, i), qat(q, base + i), exp[i]);
    endtask

    task automatic mark();
        b_beat = beat_q.size();
        b_bias = bias_q.size();
        b_arst = arst_q.size();
        b_ov   = ov_q.size();
        b_idx  = idx_q.size();
        b_done = done_q.size();
        b_bad  = bad_cnt;
    endtask

    // Drives cfg_start at relative cycle 0; returns at relative cycle 1.
    task automatic start_layer(input int acc, input int pix, input int sc);
        cfg_acc_len = AW'(acc);
        cfg_pix_num = PW'(pix);
        cfg_scale   = 4'(sc);
        cfg_start   = 1'b1;
        t0 = cyc;
        mark();
        step(1);
        cfg_start = 1'b0;
    endtask

    initial begin
        // Reset with valids asserted: nothing may be accepted.
        rst = 1'b1;
        feat_valid = 1'b1;
        wgt_valid  = 1'b1;
        step(3);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_done",   int'(done), 0);
        chk("rst_outv",   int'(out_valid), 0);
        chk("rst_scale",  int'(npu_scale), 0);
        chk("rst_arst",   int'(npu_adder_rst), 0);
        chk("rst_fready", int'(feat_ready), 0);
        chk("rst_wready", int'(wgt_ready), 0);
        chk("rst_bias",   int'(npu_bias_en), 0);
        rst = 1'b0;
        step(2);

        // 1: acc_len=3, pix_num=2, valids held high.
        start_layer(3, 2, 3);
        chk("t1_busy",  int'(busy), 1);
        chk("t1_scale", int'(npu_scale), 3);
        step(29);
        chk("t1_idle",  int'(busy), 0);
        chk_q("t1_beat", beat_q, b_beat, '{1, 2, 3, 4, 5, 6});
        chk_q("t1_bias", bias_q, b_bias, '{1, 4});
        chk_q("t1_arst", arst_q, b_arst, '{12, 15});
        chk_q("t1_ov",   ov_q,   b_ov,   '{17, 20});
        chk_q("t1_idx",  idx_q,  b_idx,  '{0, 1});
        chk_q("t1_done", done_q, b_done, '{22});
        chk("t1_proto", bad_cnt - b_bad, 0);

        // 2: same layer, weight stream valid only on odd cycles.
        wgt_valid = 1'b0;
        start_layer(3, 2, 3);
        for (int r = 1; r < 40; r++) begin
            wgt_valid = (r % 2 == 1);
            step(1);
        end
        wgt_valid = 1'b1;
        chk_q("t2_beat", beat_q, b_beat, '{1, 3, 5, 7, 9, 11});
        chk_q("t2_bias", bias_q, b_bias, '{1, 7});
        chk_q("t2_arst", arst_q, b_arst, '{12, 18});
        chk_q("t2_ov",   ov_q,   b_ov,   '{19, 25});
        chk_q("t2_idx",  idx_q,  b_idx,  '{0, 1});
        chk_q("t2_done", done_q, b_done, '{27});
        chk("t2_proto", bad_cnt - b_bad, 0);

        // 3: acc_len=0 behaves as 1; every beat is first and last.
        start_layer(0, 4, 3);
        step(29);
        chk_q("t3_bias", bias_q, b_bias, '{1, 2, 3, 4});
        chk_q("t3_arst", arst_q, b_arst, '{12, 13, 14, 15});
        chk_q("t3_ov",   ov_q,   b_ov,   '{15, 16, 17, 18});
        chk_q("t3_idx",  idx_q,  b_idx,  '{0, 1, 2, 3});
        chk_q("t3_done", done_q, b_done, '{20});
        chk("t3_proto", bad_cnt - b_bad, 0);

        // 4: empty layer goes straight to DONE.
        start_layer(3, 0, 3);
        chk("t4_busy1", int'(busy), 1);
        chk("t4_done1", int'(done), 1);
        step(1);
        chk("t4_busy2", int'(busy), 0);
        chk("t4_done2", int'(done), 0);
        step(10);
        chk("t4_beats", beat_q.size() - b_beat, 0);
        chk("t4_ov",    ov_q.size() - b_ov, 0);
        chk_q("t4_done", done_q, b_done, '{1});

        // 5: reset five cycles into a layer, then a clean rerun.
        start_layer(3, 2, 3);
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_busy",   int'(busy), 0);
        chk("t5_arst",   int'(npu_adder_rst), 0);
        chk("t5_fready", int'(feat_ready), 0);
        step(30);
        chk_q("t5_beat", beat_q, b_beat, '{1, 2, 3, 4, 5});
        chk("t5_arst_n", arst_q.size() - b_arst, 0);
        chk("t5_ov_n",   ov_q.size() - b_ov, 0);
        chk("t5_done_n", done_q.size() - b_done, 0);
        start_layer(3, 2, 3);
        step(29);
        chk_q("t5r_ov",   ov_q,   b_ov,   '{17, 20});
        chk_q("t5r_idx",  idx_q,  b_idx,  '{0, 1});
        chk_q("t5r_done", done_q, b_done, '{22});

        // 6: a second cfg_start during RUN with new config is ignored.
        start_layer(2, 3, 5);
        chk("t6_scale1", int'(npu_scale), 5);
        step(2);
        cfg_scale   = 4'd9;
        cfg_acc_len = AW'(1);
        cfg_pix_num = PW'(1);
        cfg_start   = 1'b1;
        step(1);
        cfg_start = 1'b0;
        chk("t6_scale2", int'(npu_scale), 5);
        step(26);
        chk_q("t6_ov",   ov_q,   b_ov,   '{16, 18, 20});
        chk_q("t6_idx",  idx_q,  b_idx,  '{0, 1, 2});
        chk_q("t6_done", done_q, b_done, '{22});
        chk("t6_scale3", int'(npu_scale), 5);
        chk("t6_proto", bad_cnt - b_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
